// File: rtl/dmem_responder_if.sv
// Request/response bundle between the pipeline memory stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        busy;

   modport master (
      output req_valid, req_write, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err, busy
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err, busy
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with a fixed number of wait states per access.
// One access in flight at a time: IDLE accepts, WAIT burns WAIT_CYCLES
// cycles, RESP presents a one-cycle response strobe.
// Optional feature: define DMEM_ALIGN_CHECK_EN to fault accesses whose byte
// address is not word aligned (no array write, rdata 0, resp_err 1).
module dmem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2
) (
   input logic             clk,
   input logic             reset,
   dmem_responder_if.slave bus
);

   localparam int         IDX_W    = $clog2(DEPTH_WORDS);
   localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t             state;
   state_t             state_n;
   logic [3:0]         cnt;
   logic               ready;
   logic               accept;
   logic               enter_resp;

   logic               req_mis;
   logic               lat_write;
   logic [IDX_W-1:0]   lat_idx;
   logic [31:0]        lat_wdata;
   logic               lat_mis;

   logic               acc_write;
   logic [IDX_W-1:0]   acc_idx;
   logic [31:0]        acc_wdata;
   logic               acc_mis;

   logic [31:0]        mem [DEPTH_WORDS];
   logic [31:0]        rdata_q;

   // Upper address bits only alias onto the same words.
   logic               unused_high;
   assign unused_high = ^bus.req_addr[31:IDX_W+2];

`ifdef DMEM_ALIGN_CHECK_EN
   assign req_mis = (bus.req_addr[1:0] != 2'b00);
`else
   logic unused_low;
   assign unused_low = ^bus.req_addr[1:0];
   assign req_mis    = 1'b0;
`endif

   // State register: reset aborts whatever access is in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_n;
   end

   // Next-state decode; the array is touched on the edge that enters RESP.
   always_comb begin
      state_n    = state;
      ready      = 1'b0;
      enter_resp = 1'b0;
      case (state)
         IDLE: begin
            ready = 1'b1;
            if (bus.req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  state_n    = RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_n = WAIT;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd0) begin
               state_n    = RESP;
               enter_resp = 1'b1;
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign accept = ready & bus.req_valid;

   // Wait counter: loaded on acceptance, counts down to zero in WAIT.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                             cnt <= 4'd0;
      else if (accept)                       cnt <= CNT_LOAD;
      else if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
   end

   // Capture the accepted request so later bus activity cannot disturb it.
   always_ff @(posedge clk) begin
      if (accept) begin
         lat_write <= bus.req_write;
         lat_idx   <= bus.req_addr[IDX_W+1:2];
         lat_wdata <= bus.req_wdata;
         lat_mis   <= req_mis;
      end
   end

   // With zero wait states the access completes from the live bus inputs.
   always_comb begin
      if (state == IDLE) begin
         acc_write = bus.req_write;
         acc_idx   = bus.req_addr[IDX_W+1:2];
         acc_wdata = bus.req_wdata;
         acc_mis   = req_mis;
      end else begin
         acc_write = lat_write;
         acc_idx   = lat_idx;
         acc_wdata = lat_wdata;
         acc_mis   = lat_mis;
      end
   end

   // Storage array: cleared by reset, written only when a store enters RESP.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
      end else if (enter_resp && acc_write && !acc_mis) begin
         mem[acc_idx] <= acc_wdata;
      end
   end

   // Load data is registered into RESP and forced back to zero afterwards.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                       rdata_q <= '0;
      else if (enter_resp && !acc_write && !acc_mis)   rdata_q <= mem[acc_idx];
      else                                             rdata_q <= '0;
   end

`ifdef DMEM_ALIGN_CHECK_EN
   logic err_q;

   // Fault flag follows the same one-cycle timing as the response strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) err_q <= 1'b0;
      else       err_q <= enter_resp & acc_mis;
   end

   assign bus.resp_err = err_q;
`else
   assign bus.resp_err = 1'b0;
`endif

   assign bus.req_ready  = ready;
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = rdata_q;
   assign bus.busy       = (state != IDLE);

endmodule
